// File: rtl/sccb_cfg_seq_if.sv
// Bundles the signals of the SCCB configuration sequencer other than clk/rstn.
//   master : the sequencer (drives status, table index and SCCB pins)
//   slave  : the surroundings (start pulse, table contents, SIOD pad input)
// Signals: start, busy, done, nack, rom_addr[ADDR_W], rom_data[16], sioc, siod_oe, siod_in.
interface sccb_cfg_seq_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              nack;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sioc;
    logic              siod_oe;
    logic              siod_in;

    modport master (
        input  start, rom_data, siod_in,
        output busy, done, nack, rom_addr, sioc, siod_oe
    );

    modport slave (
        output start, rom_data, siod_in,
        input  busy, done, nack, rom_addr, sioc, siod_oe
    );
endinterface

// File: rtl/sccb_cfg_seq.sv
// SCCB camera configuration sequencer. Walks a {reg_addr, reg_value} table and
// issues one 3-phase SCCB write (DEV_ID, addr, value) per entry. Entry 16'hFFFF
// ends the walk; {8'hF0, n} waits n*DELAY_UNIT clocks.
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   bus.start         1-cycle pulse, starts the walk at entry 0 (ignored when busy)
//   bus.busy/done     walk in progress / 1-cycle end pulse
//   bus.nack          sticky, set when an ACK slot reads SIOD high
//   bus.rom_addr/data table index (registered) and entry returned 1 clk later
//   bus.sioc          SCCB clock (push-pull)
//   bus.siod_oe       1 pulls SIOD low, 0 releases it
//   bus.siod_in       SIOD pad input
module sccb_cfg_seq #(
    parameter int unsigned CLK_DIV    = 30,
    parameter int unsigned DELAY_UNIT = 12000,
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    sccb_cfg_seq_if.master    bus
);

    localparam int unsigned QC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned UC_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DELAY,
        S_START,
        S_BYTE,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [QC_W-1:0]   qcnt, qcnt_n;
    logic [2:0]        qidx, qidx_n;
    logic [3:0]        bit_idx, bit_idx_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic              fwait, fwait_n;
    logic [UC_W-1:0]   ucnt, ucnt_n;
    logic [7:0]        ticks, ticks_n;
    logic [15:0]       entry, entry_n;
    logic [ADDR_W-1:0] rom_addr, rom_addr_n;
    logic              busy, busy_n;
    logic              done, done_n;
    logic              nack, nack_n;
    logic              sioc, sioc_n;
    logic              siod_oe, siod_oe_n;

    logic              qtick_c;
    logic [7:0]        cur_byte_c;
    logic [2:0]        bsel_c;
    logic              cur_bit_c;

    // Quarter-period boundary
    assign qtick_c = (qcnt == QC_W'(CLK_DIV - 1));

    // Byte currently being shifted out, MSB first
    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte_c = DEV_ID;
            2'd1:    cur_byte_c = entry[15:8];
            default: cur_byte_c = entry[7:0];
        endcase
        bsel_c    = 3'(4'd7 - bit_idx);
        cur_bit_c = cur_byte_c[bsel_c];
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            qcnt     <= '0;
            qidx     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            fwait    <= 1'b0;
            ucnt     <= '0;
            ticks    <= '0;
            entry    <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            sioc     <= 1'b1;
            siod_oe  <= 1'b0;
        end else begin
            state    <= state_n;
            qcnt     <= qcnt_n;
            qidx     <= qidx_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            fwait    <= fwait_n;
            ucnt     <= ucnt_n;
            ticks    <= ticks_n;
            entry    <= entry_n;
            rom_addr <= rom_addr_n;
            busy     <= busy_n;
            done     <= done_n;
            nack     <= nack_n;
            sioc     <= sioc_n;
            siod_oe  <= siod_oe_n;
        end
    end

    // Next-state and next-output logic; pin levels follow the current quarter
    always_comb begin
        state_n    = state;
        qcnt_n     = '0;
        qidx_n     = qidx;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        fwait_n    = fwait;
        ucnt_n     = ucnt;
        ticks_n    = ticks;
        entry_n    = entry;
        rom_addr_n = rom_addr;
        busy_n     = busy;
        done_n     = 1'b0;
        nack_n     = nack;
        sioc_n     = 1'b1;
        siod_oe_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    rom_addr_n = '0;
                    nack_n     = 1'b0;
                    busy_n     = 1'b1;
                    fwait_n    = 1'b0;
                    state_n    = S_FETCH;
                end
            end

            // First cycle lets the table respond, second cycle decodes
            S_FETCH: begin
                if (!fwait) begin
                    fwait_n = 1'b1;
                end else begin
                    fwait_n = 1'b0;
                    entry_n = bus.rom_data;
                    if (bus.rom_data == 16'hFFFF) begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else if (bus.rom_data[15:8] == 8'hF0) begin
                        if (bus.rom_data[7:0] == 8'h00) begin
                            rom_addr_n = rom_addr + ADDR_W'(1);
                            state_n    = S_FETCH;
                        end else begin
                            ticks_n = bus.rom_data[7:0];
                            ucnt_n  = '0;
                            state_n = S_DELAY;
                        end
                    end else begin
                        qidx_n  = '0;
                        state_n = S_START;
                    end
                end
            end

            S_DELAY: begin
                if (ucnt == UC_W'(DELAY_UNIT - 1)) begin
                    ucnt_n = '0;
                    if (ticks == 8'd1) begin
                        rom_addr_n = rom_addr + ADDR_W'(1);
                        fwait_n    = 1'b0;
                        state_n    = S_FETCH;
                    end else begin
                        ticks_n = ticks - 8'd1;
                    end
                end else begin
                    ucnt_n = ucnt + UC_W'(1);
                end
            end

            // SIOD falls while SIOC high, then SIOC drops
            S_START: begin
                qcnt_n    = qtick_c ? '0 : qcnt + QC_W'(1);
                sioc_n    = (qidx == 3'd0);
                siod_oe_n = 1'b1;
                if (qtick_c) begin
                    if (qidx == 3'd1) begin
                        qidx_n     = '0;
                        bit_idx_n  = '0;
                        byte_idx_n = '0;
                        state_n    = S_BYTE;
                    end else begin
                        qidx_n = qidx + 3'd1;
                    end
                end
            end

            // 8 data bits plus a released ACK bit, SIOC high in q2/q3
            S_BYTE: begin
                qcnt_n    = qtick_c ? '0 : qcnt + QC_W'(1);
                sioc_n    = qidx[1];
                siod_oe_n = (bit_idx == 4'd8) ? 1'b0 : ~cur_bit_c;
                if ((bit_idx == 4'd8) && (qidx == 3'd2) && qtick_c && bus.siod_in) begin
                    nack_n = 1'b1;
                end
                if (qtick_c) begin
                    if (qidx == 3'd3) begin
                        qidx_n = '0;
                        if (bit_idx == 4'd8) begin
                            bit_idx_n = '0;
                            if (byte_idx == 2'd2) begin
                                state_n = S_STOP;
                            end else begin
                                byte_idx_n = byte_idx + 2'd1;
                            end
                        end else begin
                            bit_idx_n = bit_idx + 4'd1;
                        end
                    end else begin
                        qidx_n = qidx + 3'd1;
                    end
                end
            end

            // Stop condition in q0..q3, then two idle quarters with SIOC high
            S_STOP: begin
                qcnt_n    = qtick_c ? '0 : qcnt + QC_W'(1);
                sioc_n    = (qidx >= 3'd2);
                siod_oe_n = (qidx <= 3'd2);
                if (qtick_c) begin
                    if (qidx == 3'd5) begin
                        qidx_n     = '0;
                        rom_addr_n = rom_addr + ADDR_W'(1);
                        fwait_n    = 1'b0;
                        state_n    = S_FETCH;
                    end else begin
                        qidx_n = qidx + 3'd1;
                    end
                end
            end

            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.nack     = nack;
    assign bus.rom_addr = rom_addr;
    assign bus.sioc     = sioc;
    assign bus.siod_oe  = siod_oe;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Directed bench for sccb_cfg_seq: table ROM, SCCB sensor/bus monitor with
// programmable ACK, and hand-computed expected byte streams.
module tb_sccb_cfg_seq;

    logic clk;
    logic rstn;

    sccb_cfg_seq_if #(.ADDR_W(8)) bus ();

    sccb_cfg_seq #(
        .CLK_DIV   (4),
        .DELAY_UNIT(10),
        .DEV_ID    (8'h42),
        .ADDR_W    (8)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table ROM: registered read, data valid 1 clk after the address
    logic [15:0] rom [0:255];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // Open-drain SIOD line: DUT or sensor can pull it low
    logic sens_low;
    logic siod_line;
    assign siod_line   = ~(bus.siod_oe | sens_low);
    assign bus.siod_in = siod_line;

    int checks;
    int errors;

    // Monitor state, written only by the monitor process
    int          cyc;
    int          bitcnt, byte_in_wr, wr_cnt, rise_n, t0;
    int          period1, gap1, stop_cyc, done_cnt, sioc_low, oe_cyc;
    logic        in_frame, prev_sioc, prev_line;
    logic [7:0]  shreg;
    logic [7:0]  bytes[$];
    logic [7:0]  addr_log[$];

    // Sensor NACK injection: write index / byte index whose ACK is left high
    int nack_wr;
    int nack_byte;

    logic [7:0] exp_q[$];

    initial begin
        cyc = 0; bitcnt = 0; byte_in_wr = 0; wr_cnt = 0; rise_n = 0; t0 = 0;
        period1 = -1; gap1 = -1; stop_cyc = -1; done_cnt = 0; sioc_low = 0; oe_cyc = 0;
        in_frame = 1'b0; prev_sioc = 1'b1; prev_line = 1'b1; shreg = '0; sens_low = 1'b0;
    end

    // Bus decoder + sensor model, sampled on the inactive clock edge
    always @(negedge clk) begin
        cyc++;
        if (bus.start && !bus.busy) begin
            bytes.delete();
            addr_log.delete();
            done_cnt = 0; wr_cnt = 0; period1 = -1; gap1 = -1; stop_cyc = -1;
            sioc_low = 0; oe_cyc = 0;
        end
        if (!rstn) begin
            in_frame = 1'b0; bitcnt = 0; sens_low = 1'b0;
            prev_sioc = 1'b1; prev_line = 1'b1;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.busy && (addr_log.size() == 0 || addr_log[$] != bus.rom_addr))
                addr_log.push_back(bus.rom_addr);
            if (!bus.sioc) sioc_low++;
            if (bus.siod_oe) oe_cyc++;
            if (bus.sioc && prev_sioc && (siod_line != prev_line)) begin
                if (!siod_line) begin
                    if (stop_cyc >= 0 && gap1 < 0) gap1 = cyc - stop_cyc;
                    in_frame = 1'b1; bitcnt = 0; byte_in_wr = 0; rise_n = 0; wr_cnt++;
                end else begin
                    in_frame = 1'b0; stop_cyc = cyc;
                end
            end else if (in_frame && bus.sioc && !prev_sioc) begin
                if (wr_cnt == 1) begin
                    if (rise_n == 0) t0 = cyc;
                    else if (rise_n == 1) period1 = cyc - t0;
                end
                rise_n++;
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], siod_line};
                    bitcnt++;
                end else begin
                    bytes.push_back(shreg);
                    bitcnt = 0;
                    byte_in_wr++;
                end
            end else if (in_frame && !bus.sioc && prev_sioc) begin
                sens_low = (bitcnt == 8) && !(((wr_cnt - 1) == nack_wr) && (byte_in_wr == nack_byte));
            end
            prev_sioc = bus.sioc;
            prev_line = siod_line;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_bytes(input string tag);
        check_eq({tag, "_count"}, bytes.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_eq($sformatf("%s_b%0d", tag, i), (i < bytes.size()) ? {24'h0, bytes[i]} : 32'hDEAD, exp_q[i]);
    endtask

    task automatic check_addr_log(input string tag);
        check_eq({tag, "_addr_n"}, addr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("%s_addr%0d", tag, i), (i < addr_log.size()) ? {24'h0, addr_log[i]} : 32'hDEAD, i);
    endtask

    task automatic load_main();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hF002;
        rom[2] = 16'h1101;
        rom[3] = 16'hFFFF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            step();
            n++;
        end
        repeat (6) step();
    endtask

    initial begin
        int lat;
        int n;
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.start = 1'b0;
        nack_wr = -1;
        nack_byte = -1;
        load_main();
        repeat (3) step();

        // Reset state
        check_eq("rst_sioc", bus.sioc, 1);
        check_eq("rst_siod_oe", bus.siod_oe, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_nack", bus.nack, 0);
        check_eq("rst_rom_addr", bus.rom_addr, 0);
        rstn = 1'b1;
        repeat (2) step();

        // Main table, all ACKs low
        exp_q = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h01};
        pulse_start();
        check_eq("main_busy", bus.busy, 1);
        wait_done(3000);
        check_bytes("main");
        check_eq("main_done_cnt", done_cnt, 1);
        check_eq("main_nack", bus.nack, 0);
        check_eq("main_gap_ge20", (gap1 >= 20), 1);
        check_eq("main_sioc_period", period1, 16);
        check_addr_log("main");
        check_eq("main_final_addr", bus.rom_addr, 3);
        check_eq("main_busy_end", bus.busy, 0);

        // ACK of the addr byte of the first write left high
        nack_wr = 0;
        nack_byte = 1;
        pulse_start();
        wait_done(3000);
        check_bytes("nack");
        check_eq("nack_done_cnt", done_cnt, 1);
        check_eq("nack_set", bus.nack, 1);
        repeat (20) step();
        check_eq("nack_sticky", bus.nack, 1);
        nack_wr = -1;
        nack_byte = -1;

        // End marker at entry 0
        rom[0] = 16'hFFFF;
        pulse_start();
        check_eq("ffff_nack_clr", bus.nack, 0);
        check_eq("ffff_busy", bus.busy, 1);
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (bus.done && lat < 0) lat = i;
        end
        check_eq("ffff_lat_le4", (lat >= 1 && lat <= 4), 1);
        check_eq("ffff_done_cnt", done_cnt, 1);
        check_eq("ffff_sioc_low", sioc_low, 0);
        check_eq("ffff_oe", oe_cyc, 0);
        check_eq("ffff_bytes", bytes.size(), 0);

        // Second start while a write is in flight
        load_main();
        exp_q = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h01};
        pulse_start();
        n = 0;
        while (bytes.size() < 2 && n < 2000) begin
            step();
            n++;
        end
        pulse_start();
        wait_done(3000);
        check_bytes("restart");
        check_eq("restart_done_cnt", done_cnt, 1);
        check_addr_log("restart");

        // Reset during the 2nd bit of the addr byte
        pulse_start();
        n = 0;
        while (!(in_frame && byte_in_wr == 1 && bitcnt == 1 && !bus.sioc) && n < 2000) begin
            step();
            n++;
        end
        check_eq("rst_mid_reached", (n < 2000), 1);
        rstn = 1'b0;
        #1;
        check_eq("rst_mid_sioc", bus.sioc, 1);
        check_eq("rst_mid_siod_oe", bus.siod_oe, 0);
        check_eq("rst_mid_busy", bus.busy, 0);
        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();
        pulse_start();
        wait_done(3000);
        check_bytes("after_rst");
        check_eq("after_rst_done_cnt", done_cnt, 1);
        check_addr_log("after_rst");

        // Zero delay entry
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'hF000;
        rom[1] = 16'h1234;
        rom[2] = 16'hFFFF;
        exp_q = '{8'h42, 8'h12, 8'h34};
        pulse_start();
        wait_done(3000);
        check_bytes("zdelay");
        check_eq("zdelay_done_cnt", done_cnt, 1);
        check_eq("zdelay_final_addr", bus.rom_addr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
